ha_iter_adder_ctrl: RTL

- Sequential controller that turns the combinational 32-bit HalfAdder into a full adder by iterating it.
- Carry-propagation loop: Sum <= S ^ C, Carry <= (S & C) << 1, repeated until Carry is 0.
- Start/Ready/Done handshake toward the ALU top.
- Reports carry-out and the number of iterations used.
- Sits between the ALU opcode decoder and the HalfAdder datapath; it owns the datapath while busy.

---
 rtl/alu_pkg.sv | 13 +
 rtl/ha_iter_adder_ctrl_halfadder.sv | 15 +
 rtl/ha_iter_adder_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding and default widths for the
// iterative adder controller and its HalfAdder datapath.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int CNT_WIDTH = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_t;

endpackage

// File: rtl/ha_iter_adder_ctrl_halfadder.sv
// Combinational WIDTH-bit half adder: bitwise sum and raw (unshifted) carry
// vectors. The controller iterates it to build a full adder.
module HalfAdder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum,
  output logic [WIDTH-1:0] Carry
);

  assign Sum   = A ^ B;
  assign Carry = A & B;

endmodule

// File: rtl/ha_iter_adder_ctrl.sv
// Iterative adder controller: repeats S^C / (S&C)<<1 through the HalfAdder
// until the carry vector is zero. Optional Overflow port via HA_ITER_OVERFLOW_EN.
module ha_iter_adder_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = CNT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             CarryOut,
  output logic [CNT_W-1:0] Iterations
`ifdef HA_ITER_OVERFLOW_EN
  ,
  output logic             Overflow
`endif
);

  state_t           r_state;
  state_t           w_nextState;
  logic             w_load;
  logic             w_step;
  logic             w_finish;

  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_c;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carryAcc;
  logic [WIDTH-1:0] w_haSum;
  logic [WIDTH-1:0] w_haCarry;

`ifdef HA_ITER_OVERFLOW_EN
  logic             r_signA;
  logic             r_signB;
`endif

  HalfAdder #(.WIDTH(WIDTH)) uHalfAdder (
    .A     (r_s),
    .B     (r_c),
    .Sum   (w_haSum),
    .Carry (w_haCarry)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  // CALC finishes on the first edge that sees an all-zero carry vector.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_load      = 1'b1;
          w_nextState = ST_CALC;
        end
      end
      ST_CALC: begin
        if (r_c != '0) begin
          w_step = 1'b1;
        end else begin
          w_finish    = 1'b1;
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  assign Ready = (r_state == ST_IDLE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_s        <= '0;
      r_c        <= '0;
      r_cnt      <= '0;
      r_carryAcc <= 1'b0;
      Done       <= 1'b0;
      Sum        <= '0;
      CarryOut   <= 1'b0;
      Iterations <= '0;
`ifdef HA_ITER_OVERFLOW_EN
      r_signA    <= 1'b0;
      r_signB    <= 1'b0;
      Overflow   <= 1'b0;
`endif
    end else begin
      Done <= w_finish;
      if (w_load) begin
        r_s        <= A;
        r_c        <= B;
        r_cnt      <= '0;
        r_carryAcc <= 1'b0;
`ifdef HA_ITER_OVERFLOW_EN
        r_signA    <= A[WIDTH-1];
        r_signB    <= B[WIDTH-1];
`endif
      end
      // A carry leaving the MSB only feeds the carry-out, never S.
      if (w_step) begin
        r_s        <= w_haSum;
        r_c        <= {w_haCarry[WIDTH-2:0], 1'b0};
        r_cnt      <= r_cnt + CNT_W'(1);
        r_carryAcc <= r_carryAcc | w_haCarry[WIDTH-1];
      end
      if (w_finish) begin
        Sum        <= r_s;
        CarryOut   <= r_carryAcc;
        Iterations <= r_cnt;
`ifdef HA_ITER_OVERFLOW_EN
        Overflow   <= (r_signA == r_signB) && (r_s[WIDTH-1] != r_signA);
`endif
      end
    end
  end

endmodule
